// File: rtl/dmux8way_deserializer_pkg.sv
// Shared constants and types for the 8-way demultiplexing deserializer.
// Slot indices double as select values for the matching 8-way word mux.
package dmux8way_deserializer_pkg;

  localparam int unsigned WORDS = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    FILL,
    FULL
  } state_e;

  localparam logic [IDX_W-1:0] SLOT_A = 3'd0;
  localparam logic [IDX_W-1:0] SLOT_B = 3'd1;
  localparam logic [IDX_W-1:0] SLOT_C = 3'd2;
  localparam logic [IDX_W-1:0] SLOT_D = 3'd3;
  localparam logic [IDX_W-1:0] SLOT_E = 3'd4;
  localparam logic [IDX_W-1:0] SLOT_F = 3'd5;
  localparam logic [IDX_W-1:0] SLOT_G = 3'd6;
  localparam logic [IDX_W-1:0] SLOT_H = 3'd7;

  // Number of words in a frame whose last word went to slot idx.
  function automatic logic [CNT_W-1:0] frame_count(logic [IDX_W-1:0] idx);
    return CNT_W'(idx) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmux8way_deserializer_if.sv
// Word stream in, eight-slot frame out, each with a valid/ready handshake.
// master: the environment feeding words and consuming frames.
// slave: the deserializer itself.
interface dmux8way_deserializer_if #(
  parameter int unsigned WIDTH = 16
);
  import dmux8way_deserializer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_e;
  logic [WIDTH-1:0] out_f;
  logic [WIDTH-1:0] out_g;
  logic [WIDTH-1:0] out_h;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count,
    input  out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count,
    output out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h
  );

endinterface

// File: rtl/dmux8way_onehot.sv
// 3-bit slot select plus enable to 8-bit one-hot slot enable.
// Bit-level inverse of the 8-way mux select; purely combinational.
module dmux8way_onehot
  import dmux8way_deserializer_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  input  logic             en,
  output logic [WORDS-1:0] onehot
);

  // Decode the select into a single enabled slot, or none when disabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      unique case (sel)
        SLOT_A:  onehot = 8'b0000_0001;
        SLOT_B:  onehot = 8'b0000_0010;
        SLOT_C:  onehot = 8'b0000_0100;
        SLOT_D:  onehot = 8'b0000_1000;
        SLOT_E:  onehot = 8'b0001_0000;
        SLOT_F:  onehot = 8'b0010_0000;
        SLOT_G:  onehot = 8'b0100_0000;
        SLOT_H:  onehot = 8'b1000_0000;
        default: onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmux8way_deserializer.sv
// Registered 1-to-8 demultiplexing deserializer. Consecutive words fill
// slots a..h; a complete (or in_last-terminated) frame is then presented
// with a valid/ready handshake. Unwritten slots read zero.
module dmux8way_deserializer
  import dmux8way_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  dmux8way_deserializer_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] slot_q [WORDS];
  logic [WIDTH-1:0] slot_d [WORDS];

  logic             in_ready;
  logic             accept;
  logic             rel;
  logic             wr_en;
  logic [IDX_W-1:0] wr_sel;
  logic             clear;
  logic [WORDS-1:0] slot_en;

  // in_ready depends only on state, out_ready and reset; never on in_valid.
  assign in_ready = ~reset & ((state_q == FILL) | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign rel      = (state_q == FULL) & bus.out_ready;

  dmux8way_onehot u_onehot (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (slot_en)
  );

  // Next-state, slot index, frame count and slot write/clear control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_sel  = idx_q;
    clear   = 1'b0;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (idx_q == SLOT_H || bus.in_last) begin
            state_d = FULL;
            count_d = frame_count(idx_q);
            idx_d   = SLOT_A;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (rel) begin
          // Releasing starts a fresh frame: clear every slot first.
          clear   = 1'b1;
          state_d = FILL;
          count_d = '0;
          idx_d   = SLOT_A;
          if (accept) begin
            wr_en  = 1'b1;
            wr_sel = SLOT_A;
            if (bus.in_last) begin
              state_d = FULL;
              count_d = frame_count(SLOT_A);
            end else begin
              idx_d = SLOT_B;
            end
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = SLOT_A;
        count_d = '0;
        clear   = 1'b1;
      end
    endcase
  end

  // Slot data path: clear on frame start, then load the enabled slot.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      slot_d[i] = slot_q[i];
      if (clear) begin
        slot_d[i] = '0;
      end
      if (slot_en[i]) begin
        slot_d[i] = bus.in_data;
      end
    end
  end

  // State, index, count and slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= SLOT_A;
      count_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      for (int i = 0; i < WORDS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_count = count_q;
  assign bus.out_a     = slot_q[SLOT_A];
  assign bus.out_b     = slot_q[SLOT_B];
  assign bus.out_c     = slot_q[SLOT_C];
  assign bus.out_d     = slot_q[SLOT_D];
  assign bus.out_e     = slot_q[SLOT_E];
  assign bus.out_f     = slot_q[SLOT_F];
  assign bus.out_g     = slot_q[SLOT_G];
  assign bus.out_h     = slot_q[SLOT_H];

endmodule

// File: tb/tb_dmux8way_deserializer.sv
// Self-checking bench: directed scenarios then random traffic, compared
// against a queue-based frame model and an 8-way mux round trip.
module tb_dmux8way_deserializer;
  import dmux8way_deserializer_pkg::*;

  logic clk;
  logic reset;

  dmux8way_deserializer_if #(.WIDTH(16)) bus ();

  dmux8way_deserializer #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: words of the frame being collected, and the held frame.
  logic [15:0] pend[$];
  bit          held;
  logic [15:0] hframe [8];
  int          hcount;

  // 8-way 16-bit mux: sel 0 = a .. 7 = h.
  function automatic logic [15:0] mux8(input logic [2:0] sel);
    case (sel)
      3'd0: return bus.out_a;
      3'd1: return bus.out_b;
      3'd2: return bus.out_c;
      3'd3: return bus.out_d;
      3'd4: return bus.out_e;
      3'd5: return bus.out_f;
      3'd6: return bus.out_g;
      default: return bus.out_h;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, clock the model, check outputs.
  task automatic step(input bit rst, input bit vld, input logic [15:0] data,
                      input bit last, input bit ordy);
    bit exp_rdy;
    bit acc;
    reset         = rst;
    bus.in_valid  = vld;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !rst && (!held || ordy);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      pend.delete();
      held = 0;
    end else begin
      acc = vld && exp_rdy;
      if (held && ordy) held = 0;
      if (acc) begin
        pend.push_back(data);
        if (pend.size() == 8 || last) begin
          held   = 1;
          hcount = pend.size();
          for (int i = 0; i < 8; i++) hframe[i] = (i < pend.size()) ? pend[i] : 16'h0;
          pend.delete();
        end
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(held));
    check("out_count", 32'(bus.out_count), held ? 32'(hcount) : 32'd0);
    if (held) begin
      for (int s = 0; s < 8; s++) begin
        check($sformatf("slot%0d", s), 32'(mux8(3'(s))), 32'(hframe[s]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    held = 0;
    hcount = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, with in_valid asserted to confirm nothing is taken.
    step(1, 1, 16'h5555, 0, 0);
    step(1, 0, 16'h0, 0, 0);

    // Full frame under backpressure.
    for (int i = 0; i < 8; i++) step(0, 1, 16'h1000 + 16'(i), 0, 0);

    // Hold: nothing accepted, outputs stable.
    for (int i = 0; i < 5; i++) step(0, 1, 16'hDEAD, 0, 0);
    // Release and accept 0xDEAD into slot a in the same cycle; close with 0xBEEF.
    step(0, 1, 16'hDEAD, 0, 1);
    step(0, 1, 16'hBEEF, 1, 0);
    step(0, 0, 16'h0, 0, 1);

    // Short frame: zeros above out_count.
    step(0, 1, 16'h000A, 0, 0);
    step(0, 1, 16'h000B, 0, 0);
    step(0, 1, 16'h000C, 1, 0);
    step(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 1);

    // Single-word frames back-to-back, no stall.
    for (int i = 0; i < 6; i++) step(0, 1, 16'($urandom), 1, 1);
    step(0, 0, 16'h0, 0, 1);

    // Mid-frame reset discards the partial frame.
    for (int i = 0; i < 4; i++) step(0, 1, 16'h7700 + 16'(i), 0, 0);
    step(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'(i), 0, 0);
    step(0, 0, 16'h0, 0, 1);

    // In_last on the 8th word behaves like a plain 8th word.
    for (int i = 0; i < 8; i++) step(0, 1, 16'h2000 + 16'(i), i == 7, 0);
    step(0, 0, 16'h0, 0, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
